edfic_nest_ctrl: RTL



---
 rtl/edfic_nest_pkg.sv | 30 +++
 rtl/edfic_nest_stack.sv | 84 ++++++++
 rtl/edfic_nest_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/edfic_nest_pkg.sv
// rtl/edfic_nest_pkg.sv - shared types and helpers for the EDF nesting controller
//
// Contents:
//   state_e    delivery sequencer states (IDLE, OFFER, ACK)
//   STATS_W    width of the optional claim/miss statistics counters
//   idx_width  index width for a stack of a given depth (at least 1 bit)
//   sat_inc    saturating increment for the statistics counters
//
// The stack entry struct depends on module parameters, so it is declared
// inside edfic_nest_stack where IdWidth/DlWidth are known.

package edfic_nest_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam int STATS_W = 16;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/edfic_nest_stack.sv
// rtl/edfic_nest_stack.sv - LIFO of running interrupts {id, absolute deadline, reported}
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push            write {push_id, push_abs, reported=0} as the new top
//   push_id/abs     entry contents for push
//   pop             remove the top entry (ignored when empty)
//   set_reported    mark the current top entry as already reported missed
//   level           number of valid entries (0..Depth)
//   top_id/abs      top entry fields, zero when empty
//   top_reported    top entry reported flag, zero when empty
//
// push and pop together replace the top entry and leave level unchanged.

module edfic_nest_stack
    import edfic_nest_pkg::*;
#(
    parameter int IdWidth  = 2,
    parameter int DlWidth  = 24,
    parameter int Depth    = 4,
    parameter int LvlWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push,
    input  logic [IdWidth-1:0]  push_id,
    input  logic [DlWidth-1:0]  push_abs,
    input  logic                pop,
    input  logic                set_reported,
    output logic [LvlWidth-1:0] level,
    output logic [IdWidth-1:0]  top_id,
    output logic [DlWidth-1:0]  top_abs,
    output logic                top_reported
);

    localparam int IdxW = idx_width(Depth);
    localparam logic [LvlWidth-1:0] DepthL = LvlWidth'(Depth);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [DlWidth-1:0] abs_dl;
        logic               reported;
    } entry_t;

    entry_t              mem [Depth];
    logic [LvlWidth-1:0] lvl_q;
    logic                empty;
    logic                full;
    logic [IdxW-1:0]     top_idx;
    logic [IdxW-1:0]     nxt_idx;

    assign empty   = (lvl_q == '0);
    assign full    = (lvl_q == DepthL);
    assign top_idx = IdxW'(lvl_q - LvlWidth'(1));
    assign nxt_idx = IdxW'(lvl_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (set_reported && !empty) begin
                mem[top_idx].reported <= 1'b1;
            end
            // A replacing push must win over set_reported on the same slot.
            if (push && pop && !empty) begin
                mem[top_idx] <= '{id: push_id, abs_dl: push_abs, reported: 1'b0};
            end else if (push && !full) begin
                mem[nxt_idx] <= '{id: push_id, abs_dl: push_abs, reported: 1'b0};
                lvl_q        <= lvl_q + LvlWidth'(1);
            end else if (pop && !empty) begin
                lvl_q <= lvl_q - LvlWidth'(1);
            end
        end
    end

    assign level        = lvl_q;
    assign top_id       = empty ? '0 : mem[top_idx].id;
    assign top_abs      = empty ? '0 : mem[top_idx].abs_dl;
    assign top_reported = empty ? 1'b0 : mem[top_idx].reported;

endmodule

// File: rtl/edfic_nest_ctrl.sv
// rtl/edfic_nest_ctrl.sv - EDF interrupt delivery sequencer with preemptive nesting
//
// Optional feature macro: EDFIC_NEST_STATS_EN (claim/miss counters; tied to 0 when undefined)
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   mtime_i                   platform time; DlWidth bits from DlClip form "now"
//   irq_valid_i/id_i/dl_i     controller winner; dl is relative to now
//   irq_ack_o/ack_id_o        one-cycle claim pulse back to the controller
//   core_irq_o/core_irq_id_o  interrupt offered to the hart
//   core_claim_i              hart takes the offered interrupt
//   core_done_i               hart returned from the innermost handler
//   level_o, cur_id_o         nesting depth and id on top of stack
//   miss_o, miss_id_o         one-cycle pulse when the top entry's deadline passes
//   err_o                     sticky: completion seen with nothing running
//   claim_cnt_o, miss_cnt_o   saturating statistics counters

module edfic_nest_ctrl
    import edfic_nest_pkg::*;
#(
    parameter int NrIrqs   = 4,
    parameter int IdWidth  = $clog2(NrIrqs),
    parameter int DlWidth  = 24,
    parameter int DlClip   = 0,
    parameter int Depth    = 4,
    parameter int LvlWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [63:0]         mtime_i,
    input  logic                irq_valid_i,
    input  logic [IdWidth-1:0]  irq_id_i,
    input  logic [DlWidth-1:0]  irq_dl_i,
    output logic                irq_ack_o,
    output logic [IdWidth-1:0]  irq_ack_id_o,
    output logic                core_irq_o,
    output logic [IdWidth-1:0]  core_irq_id_o,
    input  logic                core_claim_i,
    input  logic                core_done_i,
    output logic [LvlWidth-1:0] level_o,
    output logic [IdWidth-1:0]  cur_id_o,
    output logic                miss_o,
    output logic [IdWidth-1:0]  miss_id_o,
    output logic                err_o,
    output logic [STATS_W-1:0]  claim_cnt_o,
    output logic [STATS_W-1:0]  miss_cnt_o
);

    localparam logic [LvlWidth-1:0] DepthL = LvlWidth'(Depth);

    state_e              state_q, state_d;
    logic [IdWidth-1:0]  lid_q;
    logic [DlWidth-1:0]  labs_q;
    logic [DlWidth-1:0]  now;
    logic [DlWidth-1:0]  abs_new;
    logic [DlWidth-1:0]  top_slack;
    logic [LvlWidth-1:0] level;
    logic [IdWidth-1:0]  top_id;
    logic [DlWidth-1:0]  top_abs;
    logic                top_reported;
    logic                preempt;
    logic                withdraw;
    logic                miss_cond;
    logic                miss_q;
    logic [IdWidth-1:0]  miss_id_q;
    logic                err_q;
    logic                unused_mtime;

    // Only a window of mtime is used; fold the rest so it is not left dangling.
    assign unused_mtime = ^mtime_i;

    assign now       = mtime_i[DlClip +: DlWidth];
    assign abs_new   = irq_dl_i + now;
    assign top_slack = top_abs - now;

    // Strictly earlier than the running handler's remaining slack; ties never preempt.
    assign preempt = irq_valid_i && (level < DepthL) &&
                     ((level == '0) || (irq_dl_i < top_slack));

    // A completion in the same cycle only raises the threshold, so the stale
    // comparison is not allowed to withdraw; the next cycle sees the popped stack.
    assign withdraw = !irq_valid_i || (irq_id_i != lid_q) || (!core_done_i && !preempt);

    // Slack wraps negative once the deadline is behind now.
    assign miss_cond = (level != '0) && top_slack[DlWidth-1] && !top_reported;

    edfic_nest_stack #(
        .IdWidth (IdWidth),
        .DlWidth (DlWidth),
        .Depth   (Depth),
        .LvlWidth(LvlWidth)
    ) u_stack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push        (state_q == ACK),
        .push_id     (lid_q),
        .push_abs    (labs_q),
        .pop         (core_done_i),
        .set_reported(miss_cond),
        .level       (level),
        .top_id      (top_id),
        .top_abs     (top_abs),
        .top_reported(top_reported)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (preempt) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (core_claim_i) begin
                    state_d = ACK;
                end else if (withdraw) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_irq_o    = 1'b0;
        core_irq_id_o = '0;
        irq_ack_o     = 1'b0;
        irq_ack_id_o  = '0;
        unique case (state_q)
            OFFER: begin
                core_irq_o    = 1'b1;
                core_irq_id_o = lid_q;
            end
            ACK: begin
                irq_ack_o    = 1'b1;
                irq_ack_id_o = lid_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lid_q     <= '0;
            labs_q    <= '0;
            miss_q    <= 1'b0;
            miss_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && preempt) begin
                lid_q  <= irq_id_i;
                labs_q <= abs_new;
            end
            miss_q <= miss_cond;
            if (miss_cond) begin
                miss_id_q <= top_id;
            end
            if (core_done_i && level == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign level_o   = level;
    assign cur_id_o  = top_id;
    assign miss_o    = miss_q;
    assign miss_id_o = miss_id_q;
    assign err_o     = err_q;

`ifdef EDFIC_NEST_STATS_EN
    logic [STATS_W-1:0] claim_cnt_q;
    logic [STATS_W-1:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            claim_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (state_q == ACK) begin
                claim_cnt_q <= sat_inc(claim_cnt_q);
            end
            if (miss_cond) begin
                miss_cnt_q <= sat_inc(miss_cnt_q);
            end
        end
    end

    assign claim_cnt_o = claim_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
`else
    assign claim_cnt_o = '0;
    assign miss_cnt_o  = '0;
`endif

endmodule
